// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: matches a runtime-loaded 1..MAX_LEN bit
// pattern on a qualified serial stream, with overlap control and a saturating match counter.
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               overlap_i,
    input  logic               din_valid,
    input  logic               din,
    input  logic               clr,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat,
    output logic               cfg_err,
    output logic               running
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;
    logic               len_ok;

    assign hist_n = {hist_q[MAX_LEN-2:0], din};
    assign fill_n = (fill_q == MAX_LEN_V) ? fill_q : fill_q + 1'b1;
    assign len_ok = (len_i != '0) && (len_i <= MAX_LEN_V);

    // Only the newest len_q history bits take part in the compare.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign hit = (fill_n >= len_q) && (((hist_n ^ pat_q) & len_mask) == '0);

    // NOTE: every variable gets its default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        err_d   = err_q;
        dout_d  = 1'b0;
        cnt_d   = clr ? '0 : cnt_q;
        sat_d   = clr ? 1'b0 : sat_q;

        if (load) begin
            pat_d   = pat_i;
            len_d   = len_i;
            ovl_d   = overlap_i;
            hist_d  = '0;
            fill_d  = '0;
            state_d = len_ok ? RUN : IDLE;
            err_d   = !len_ok;
        end else if (state_q == RUN && din_valid) begin
            hist_d = hist_n;
            fill_d = fill_n;
            if (hit) begin
                dout_d = 1'b1;
                // Non-overlap: the next match must be built from len fresh bits.
                if (!ovl_q) fill_d = '0;
                if (cnt_d == CNT_MAX) sat_d = 1'b1;
                else                  cnt_d = cnt_d + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            dout_q  <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    assign dout      = dout_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
    assign cfg_err   = err_q;
    assign running   = (state_q == RUN);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the detector.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load = 1'b0;
    logic [MAX_LEN-1:0] pat_i = '0;
    logic [LEN_W-1:0]   len_i = '0;
    logic               overlap_i = 1'b0;
    logic               din_valid = 1'b0;
    logic               din = 1'b0;
    logic               clr = 1'b0;
    logic               dout;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;
    logic               cfg_err;
    logic               running;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    bit                 m_run, m_err, m_ovl, m_sat, m_dout;
    bit [MAX_LEN-1:0]   m_pat;
    int                 m_len, m_cnt;
    bit                 m_hist[$];

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .load(load), .pat_i(pat_i), .len_i(len_i),
        .overlap_i(overlap_i), .din_valid(din_valid), .din(din), .clr(clr),
        .dout(dout), .match_cnt(match_cnt), .cnt_sat(cnt_sat),
        .cfg_err(cfg_err), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_err = 0; m_ovl = 0; m_sat = 0; m_dout = 0;
        m_pat = '0; m_len = 0; m_cnt = 0;
        m_hist.delete();
    endtask

    // One clock edge of the specified behaviour, expressed on a queue of received bits.
    task automatic model_edge(input bit ld, input bit [MAX_LEN-1:0] p, input int l,
                              input bit ov, input bit dv, input bit d, input bit cl);
        bit tail_ok;
        m_dout = 0;
        if (cl) begin m_cnt = 0; m_sat = 0; end
        if (ld) begin
            m_pat = p; m_len = l; m_ovl = ov;
            m_hist.delete();
            m_run = (l >= 1 && l <= MAX_LEN);
            m_err = !m_run;
        end else if (m_run && dv) begin
            m_hist.push_back(d);
            if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
            tail_ok = (m_hist.size() >= m_len);
            for (int k = 0; k < m_len && tail_ok; k++)
                if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) tail_ok = 0;
            if (tail_ok) begin
                m_dout = 1;
                if (!m_ovl) m_hist.delete();
                if (m_cnt == CNT_MAX) m_sat = 1;
                else                  m_cnt++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_dout"}, dout, m_dout);
        check({tag, "_cnt"}, match_cnt, m_cnt);
        check({tag, "_sat"}, cnt_sat, m_sat);
        check({tag, "_err"}, cfg_err, m_err);
        check({tag, "_run"}, running, m_run);
    endtask

    // Drive one cycle of inputs, clock it, then compare just after the edge.
    task automatic step(input string tag, input bit ld, input bit [MAX_LEN-1:0] p,
                        input int l, input bit ov, input bit dv, input bit d, input bit cl);
        load = ld; pat_i = p; len_i = LEN_W'(l); overlap_i = ov;
        din_valid = dv; din = d; clr = cl;
        @(posedge clk);
        model_edge(ld, p, l, ov, dv, d, cl);
        #1;
        check_all(tag);
    endtask

    task automatic cfg(input bit [MAX_LEN-1:0] p, input int l, input bit ov);
        step("load", 1, p, l, ov, 0, 0, 0);
    endtask

    task automatic send(input bit d);
        step("bit", 0, '0, 0, 0, 1, d, 0);
    endtask

    task automatic gap();
        step("gap", 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        load = 0; din_valid = 0; din = 0; clr = 0;
        rst = 1;
        #2;
        model_reset();
        check_all("rst");
        rst = 0;
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("por");
        rst = 0;
        #1;

        // 1: 101 overlapping on 1,0,1,0,1
        cfg(8'b101, 3, 1);
        send(1); send(0); send(1);
        check("t1_first", dout, 1);
        send(0); send(1);
        check("t1_second", dout, 1);
        check("t1_cnt", match_cnt, 2);

        // 2: 101 non-overlapping, then 0,1 completes a second match
        do_reset();
        cfg(8'b101, 3, 0);
        send(1); send(0); send(1); send(0); send(1);
        check("t2_no_overlap", dout, 0);
        check("t2_cnt1", match_cnt, 1);
        send(0); send(1);
        check("t2_second", dout, 1);
        check("t2_cnt2", match_cnt, 2);

        // 3: eight ones, overlap then non-overlap
        do_reset();
        cfg(8'hFF, 8, 1);
        for (int i = 0; i < 10; i++) send(1);
        check("t3_cnt_ovl", match_cnt, 3);
        check("t3_sat_by_inc", cnt_sat, 0);
        do_reset();
        cfg(8'hFF, 8, 0);
        for (int i = 0; i < 10; i++) send(1);
        check("t3_cnt_novl", match_cnt, 1);

        // 4: illegal lengths, then a legal reload
        do_reset();
        cfg(8'b1, 0, 1);
        check("t4_err0", cfg_err, 1);
        send(1); send(1);
        cfg(8'b1, 9, 1);
        check("t4_err9", cfg_err, 1);
        check("t4_idle", running, 0);
        send(1); send(1);
        cfg(8'b10, 2, 1);
        check("t4_ok", cfg_err, 0);
        check("t4_run", running, 1);

        // 5: len=1 saturating counter, then clr coincident with a match
        do_reset();
        cfg(8'b1, 1, 0);
        for (int i = 0; i < 5; i++) send(1);
        check("t5_cnt_hold", match_cnt, 3);
        check("t5_sat", cnt_sat, 1);
        step("t5_clr_hit", 0, '0, 0, 0, 1, 1, 1);
        check("t5_clr_cnt", match_cnt, 1);
        check("t5_clr_sat", cnt_sat, 0);

        // 6: valid gaps are transparent; reset mid-stream drops config
        do_reset();
        cfg(8'b101, 3, 1);
        send(1); gap(); send(0); gap(); gap(); send(1);
        check("t6_gap_hit", dout, 1);
        send(0); send(1);
        rst = 1; #1;
        check("t6_async_dout", dout, 0);
        rst = 0; model_reset(); #1;
        send(1);
        check("t6_post_rst", dout, 0);
        check("t6_post_run", running, 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 5) begin
                do_reset();
            end else if (r < 40) begin
                int l;
                if ($urandom_range(0, 9) == 0) l = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15));
                else if ($urandom_range(0, 1) == 0) l = int'($urandom_range(1, 3));
                else l = int'($urandom_range(1, 8));
                step("rnd_load", 1, MAX_LEN'($urandom), l, 1'($urandom),
                     1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
            end else begin
                step("rnd", 0, MAX_LEN'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                     ($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 49) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
